// File: rtl/exc_commit_ctrl.sv
// Commit-point controller: picks the highest-priority exception/interrupt/ERTN in WB, pulses the CSR file,
// holds the pipe flushed for at least FLUSH_MIN cycles, then hands fetch a valid/ready redirect.
module exc_commit_ctrl #(
   parameter int unsigned FLUSH_MIN = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc,
   input  logic [4:0]  wb_exc,
   input  logic        wb_ertn,
   input  logic [31:0] wb_vaddr,
   input  logic        has_int,
   input  logic [31:0] csr_eentry_pc,
   input  logic [31:0] csr_eertn_pc,
   output logic        wb_ready,
   output logic        wb_commit,
   output logic [5:0]  csr_exc,
   output logic        csr_ertn_flush,
   output logic [31:0] csr_wb_pc,
   output logic [31:0] csr_badv,
   output logic        pipe_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SIGNAL   = 2'd1,
      FLUSH    = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   localparam logic [3:0] FMIN = 4'(FLUSH_MIN);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  cause_q, cause_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] badv_q, badv_d;
   logic        ertn_q, ertn_d;

   logic        ev;
   logic        any_exc;
   logic [5:0]  cause_sel;
   logic        ertn_sel;
   logic [31:0] badv_sel;

   // wb_exc = {ADEF,ALE,BRK,INE,SYS}; cause is one-hot {INT,ADEF,ALE,BRK,INE,SYS}
   // with priority INT > ADEF > INE > SYS > BRK > ALE.
   always_comb begin
      any_exc      = |wb_exc;
      ev           = wb_valid & (has_int | any_exc | wb_ertn);
      cause_sel    = 6'b0;
      cause_sel[5] = has_int;
      cause_sel[4] = ~has_int & wb_exc[4];
      cause_sel[1] = ~has_int & ~wb_exc[4] & wb_exc[1];
      cause_sel[0] = ~has_int & ~wb_exc[4] & ~wb_exc[1] & wb_exc[0];
      cause_sel[2] = ~has_int & ~wb_exc[4] & ~wb_exc[1] & ~wb_exc[0] & wb_exc[2];
      cause_sel[3] = ~has_int & ~wb_exc[4] & ~wb_exc[1] & ~wb_exc[0] & ~wb_exc[2] & wb_exc[3];
      // An ERTN sharing WB with any exception or interrupt is dropped outright.
      ertn_sel     = wb_ertn & ~has_int & ~any_exc;
      badv_sel     = cause_sel[4] ? wb_pc : (cause_sel[3] ? wb_vaddr : 32'h0);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         cause_q <= 6'd0;
         pc_q    <= 32'd0;
         badv_q  <= 32'd0;
         ertn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         badv_q  <= badv_d;
         ertn_q  <= ertn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      badv_d  = badv_q;
      ertn_d  = ertn_q;
      case (state_q)
         IDLE: begin
            cnt_d = 4'd0;
            if (ev) begin
               state_d = SIGNAL;
               cause_d = cause_sel;
               pc_d    = wb_pc;
               badv_d  = badv_sel;
               ertn_d  = ertn_sel;
            end
         end
         SIGNAL: begin
            cnt_d   = 4'd1;
            state_d = FLUSH;
         end
         FLUSH: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q >= FMIN) state_d = REDIRECT;
         end
         REDIRECT: begin
            cnt_d = 4'd0;
            if (redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign csr_wb_pc = pc_q;
   assign csr_badv  = badv_q;

   always_comb begin
      wb_ready       = 1'b0;
      wb_commit      = 1'b0;
      csr_exc        = 6'b0;
      csr_ertn_flush = 1'b0;
      pipe_flush     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      case (state_q)
         IDLE: begin
            wb_ready  = 1'b1;
            wb_commit = resetn & wb_valid & ~ev;
         end
         SIGNAL: begin
            csr_exc        = cause_q;
            csr_ertn_flush = ertn_q;
            pipe_flush     = 1'b1;
         end
         FLUSH: begin
            pipe_flush = 1'b1;
         end
         REDIRECT: begin
            pipe_flush     = 1'b1;
            redirect_valid = 1'b1;
            // CSR file updated during SIGNAL, so its outputs are already current here.
            redirect_pc    = ertn_q ? csr_eertn_pc : csr_eentry_pc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl (FLUSH_MIN = 2): inputs change and outputs are sampled
// 2 ns after the rising edge, with a further 1 ns settle before combinational checks.
module tb_exc_commit_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [4:0]  wb_exc;
   logic        wb_ertn;
   logic [31:0] wb_vaddr;
   logic        has_int;
   logic [31:0] csr_eentry_pc;
   logic [31:0] csr_eertn_pc;
   logic        wb_ready;
   logic        wb_commit;
   logic [5:0]  csr_exc;
   logic        csr_ertn_flush;
   logic [31:0] csr_wb_pc;
   logic [31:0] csr_badv;
   logic        pipe_flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   int total  = 0;
   int passes = 0;

   always #5 clk = ~clk;

   exc_commit_ctrl #(.FLUSH_MIN(2)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .wb_valid       (wb_valid),
      .wb_pc          (wb_pc),
      .wb_exc         (wb_exc),
      .wb_ertn        (wb_ertn),
      .wb_vaddr       (wb_vaddr),
      .has_int        (has_int),
      .csr_eentry_pc  (csr_eentry_pc),
      .csr_eertn_pc   (csr_eertn_pc),
      .wb_ready       (wb_ready),
      .wb_commit      (wb_commit),
      .csr_exc        (csr_exc),
      .csr_ertn_flush (csr_ertn_flush),
      .csr_wb_pc      (csr_wb_pc),
      .csr_badv       (csr_badv),
      .pipe_flush     (pipe_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wb_idle();
      wb_valid = 1'b0;
      wb_pc    = 32'h0;
      wb_exc   = 5'b0;
      wb_ertn  = 1'b0;
      wb_vaddr = 32'h0;
      has_int  = 1'b0;
   endtask

   initial begin
      resetn         = 1'b0;
      redirect_ready = 1'b1;
      csr_eentry_pc  = 32'h1c008000;
      csr_eertn_pc   = 32'h1c000204;
      wb_idle();
      tick();
      tick();
      resetn = 1'b1;
      #1;
      chk("rst_wb_ready", 32'(wb_ready), 32'd1);
      chk("rst_flush", 32'(pipe_flush), 32'd0);
      chk("rst_rvalid", 32'(redirect_valid), 32'd0);
      chk("rst_exc", 32'(csr_exc), 32'd0);
      chk("rst_wbpc", csr_wb_pc, 32'd0);

      // SYS: pulse at T+1, flush T+1..T+4, redirect at T+4
      wb_valid = 1'b1; wb_pc = 32'h1c000100; wb_exc = 5'b00001;
      #1;
      chk("sys_commit", 32'(wb_commit), 32'd0);
      tick();
      wb_idle();
      #1;
      chk("sys_exc", 32'(csr_exc), 32'h01);
      chk("sys_flush1", 32'(pipe_flush), 32'd1);
      chk("sys_wbpc", csr_wb_pc, 32'h1c000100);
      chk("sys_badv", csr_badv, 32'd0);
      chk("sys_ready_lo", 32'(wb_ready), 32'd0);
      tick();
      chk("sys_exc_once", 32'(csr_exc), 32'd0);
      chk("sys_flush2", 32'(pipe_flush), 32'd1);
      tick();
      chk("sys_flush3", 32'(pipe_flush), 32'd1);
      chk("sys_rvalid_early", 32'(redirect_valid), 32'd0);
      tick();
      chk("sys_rvalid", 32'(redirect_valid), 32'd1);
      chk("sys_rpc", redirect_pc, 32'h1c008000);
      chk("sys_flush4", 32'(pipe_flush), 32'd1);
      tick();
      chk("sys_flush_drop", 32'(pipe_flush), 32'd0);
      chk("sys_idle_ready", 32'(wb_ready), 32'd1);

      // ERTN
      wb_valid = 1'b1; wb_pc = 32'h1c000300; wb_ertn = 1'b1;
      tick();
      wb_idle();
      #1;
      chk("ertn_pulse", 32'(csr_ertn_flush), 32'd1);
      chk("ertn_exc", 32'(csr_exc), 32'd0);
      tick();
      chk("ertn_once", 32'(csr_ertn_flush), 32'd0);
      tick();
      tick();
      chk("ertn_rvalid", 32'(redirect_valid), 32'd1);
      chk("ertn_rpc", redirect_pc, 32'h1c000204);
      tick();

      // Interrupt over ADEF|ALE and ERTN
      wb_valid = 1'b1; wb_pc = 32'h1c000400; wb_exc = 5'b11000; wb_ertn = 1'b1;
      wb_vaddr = 32'hdeadbeef; has_int = 1'b1;
      #1;
      chk("int_commit", 32'(wb_commit), 32'd0);
      tick();
      wb_idle();
      #1;
      chk("int_exc", 32'(csr_exc), 32'h20);
      chk("int_no_ertn", 32'(csr_ertn_flush), 32'd0);
      chk("int_badv", csr_badv, 32'd0);
      tick();
      tick();
      tick();
      chk("int_rpc", redirect_pc, 32'h1c008000);
      tick();

      // ALE, then ADEF back-to-back in the IDLE cycle after the handshake
      wb_valid = 1'b1; wb_pc = 32'h1c000500; wb_exc = 5'b01000; wb_vaddr = 32'h800000a3;
      tick();
      wb_idle();
      #1;
      chk("ale_exc", 32'(csr_exc), 32'h08);
      chk("ale_badv", csr_badv, 32'h800000a3);
      tick();
      tick();
      tick();
      chk("ale_rvalid", 32'(redirect_valid), 32'd1);
      tick();
      wb_valid = 1'b1; wb_pc = 32'h1c000002; wb_exc = 5'b10000;
      #1;
      chk("b2b_ready", 32'(wb_ready), 32'd1);
      tick();
      wb_idle();
      redirect_ready = 1'b0;
      #1;
      chk("adef_exc", 32'(csr_exc), 32'h10);
      chk("adef_badv", csr_badv, 32'h1c000002);
      tick();
      tick();
      tick();

      // Redirect stalled for 5 cycles while WB presents a new exception
      wb_valid = 1'b1; wb_pc = 32'h1c000600; wb_exc = 5'b00001;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_rvalid", 32'(redirect_valid), 32'd1);
         chk("hold_rpc", redirect_pc, 32'h1c008000);
         chk("hold_flush", 32'(pipe_flush), 32'd1);
         chk("hold_wb_ready", 32'(wb_ready), 32'd0);
         chk("hold_commit", 32'(wb_commit), 32'd0);
         tick();
      end
      wb_idle();
      redirect_ready = 1'b1;
      #1;
      chk("hold_still", 32'(redirect_valid), 32'd1);
      tick();
      chk("hold_release_flush", 32'(pipe_flush), 32'd0);
      chk("hold_release_ready", 32'(wb_ready), 32'd1);
      tick();
      chk("hold_ignored_exc", 32'(csr_exc), 32'd0);
      chk("hold_ignored_flush", 32'(pipe_flush), 32'd0);

      // Reset mid-FLUSH
      wb_valid = 1'b1; wb_pc = 32'h1c000700; wb_exc = 5'b00001;
      tick();
      wb_idle();
      tick();
      chk("mid_in_flush", 32'(pipe_flush), 32'd1);
      resetn = 1'b0;
      tick();
      chk("mrst_ready", 32'(wb_ready), 32'd1);
      chk("mrst_flush", 32'(pipe_flush), 32'd0);
      chk("mrst_rvalid", 32'(redirect_valid), 32'd0);
      chk("mrst_exc", 32'(csr_exc), 32'd0);
      chk("mrst_ertn", 32'(csr_ertn_flush), 32'd0);
      chk("mrst_wbpc", csr_wb_pc, 32'd0);
      chk("mrst_commit", 32'(wb_commit), 32'd0);
      resetn = 1'b1;
      wb_valid = 1'b1; wb_pc = 32'h1c000800;
      #1;
      chk("post_commit", 32'(wb_commit), 32'd1);
      chk("post_exc", 32'(csr_exc), 32'd0);
      tick();
      wb_idle();
      #1;
      chk("post_no_pulse", 32'(csr_exc), 32'd0);
      chk("post_no_flush", 32'(pipe_flush), 32'd0);
      chk("post_ready", 32'(wb_ready), 32'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
